// File: rtl/pwm_deadtime_leg.sv
// pwm_deadtime_leg: one half-bridge leg of a carrier-compare PWM modulator.
// Compares a shared triangle carrier against a double-buffered duty value and
// drives complementary, registered gate commands separated by a programmable
// dead time. gate_hi and gate_lo are never asserted together.
//
// Build option:
//   PWM_PEAK_UPDATE_EN - when defined, the pending duty value is also copied to
//                        the active register at the carrier peak (double-rate
//                        update). When undefined, only the valley updates it.
module pwm_deadtime_leg #(
    parameter int unsigned CW  = 16,
    parameter int unsigned DTW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [CW-1:0]  carrier,
    input  logic [CW-1:0]  carrier_max,
    input  logic [CW-1:0]  duty,
    input  logic           duty_valid,
    input  logic [DTW-1:0] deadtime,
    output logic           gate_hi,
    output logic           gate_lo,
    output logic [CW-1:0]  duty_active,
    output logic           update_tick
);

    typedef enum logic [1:0] {
        StOff,
        StHi,
        StLo,
        StDt
    } state_e;

    // Carrier history and duty shadow registers
    logic [CW-1:0]  carrier_q;
    logic [CW-1:0]  pending_q;
    logic           pend_flag_q;
    logic [CW-1:0]  duty_active_q;
    logic           update_tick_q;

    // Compare result
    logic [CW:0]    carrier_max_p1;
    logic [CW:0]    duty_ext;
    logic [CW:0]    duty_eff;
    logic           want_hi_d;
    logic           want_hi_q;

    // Gate state machine
    state_e         state_q, state_d;
    logic           tgt_hi_q, tgt_hi_d;
    logic [DTW-1:0] dt_cnt_q, dt_cnt_d;
    logic           gate_hi_q, gate_hi_d;
    logic           gate_lo_q, gate_lo_d;

    // Transfer events
    logic           valley_evt;
    logic           xfer_evt;
    logic           xfer_go;

    // Detect the carrier reaching an extreme; the delayed copy makes it one event per visit.
    always_comb begin
        valley_evt = (carrier == '0) && (carrier_q != '0);
`ifdef PWM_PEAK_UPDATE_EN
        xfer_evt   = valley_evt ||
                     ((carrier == carrier_max) && (carrier_q != carrier_max));
`else
        xfer_evt   = valley_evt;
`endif
        xfer_go    = xfer_evt && pend_flag_q;
    end

    // Carrier delay line; resets to 1 so the first valley after reset counts as an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carrier_q <= CW'(1);
        end else begin
            carrier_q <= carrier;
        end
    end

    // Pending duty register: last strobe wins, transfer consumes the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
        end else begin
            if (duty_valid) begin
                // A strobe coincident with a transfer keeps the new value pending.
                pending_q   <= duty;
                pend_flag_q <= 1'b1;
            end else if (xfer_go) begin
                pend_flag_q <= 1'b0;
            end
        end
    end

    // Active duty register and its update pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active_q <= '0;
            update_tick_q <= 1'b0;
        end else begin
            update_tick_q <= xfer_go;
            if (xfer_go) begin
                duty_active_q <= pending_q;
            end
        end
    end

    // Clamp duty to carrier_max+1 in CW+1 bits so an over-range duty stays fully high.
    always_comb begin
        carrier_max_p1 = {1'b0, carrier_max} + (CW+1)'(1);
        duty_ext       = {1'b0, duty_active_q};
        duty_eff       = (duty_ext < carrier_max_p1) ? duty_ext : carrier_max_p1;
        want_hi_d      = ({1'b0, carrier} < duty_eff);
    end

    // Registered compare result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            want_hi_q <= 1'b0;
        end else begin
            want_hi_q <= want_hi_d;
        end
    end

    // Next-state logic: every on-transition passes through the dead-time state.
    always_comb begin
        state_d  = state_q;
        tgt_hi_d = tgt_hi_q;
        dt_cnt_d = dt_cnt_q;
        if (!enable) begin
            state_d  = StOff;
            dt_cnt_d = '0;
        end else begin
            case (state_q)
                StOff: begin
                    state_d  = StDt;
                    tgt_hi_d = want_hi_q;
                    dt_cnt_d = deadtime;
                end
                StHi: begin
                    if (!want_hi_q) begin
                        state_d  = StDt;
                        tgt_hi_d = 1'b0;
                        dt_cnt_d = deadtime;
                    end
                end
                StLo: begin
                    if (want_hi_q) begin
                        state_d  = StDt;
                        tgt_hi_d = 1'b1;
                        dt_cnt_d = deadtime;
                    end
                end
                StDt: begin
                    if (want_hi_q != tgt_hi_q) begin
                        // Request reversed mid dead time: restart the full interval.
                        tgt_hi_d = want_hi_q;
                        dt_cnt_d = deadtime;
                    end else if (dt_cnt_q == '0) begin
                        state_d = tgt_hi_q ? StHi : StLo;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DTW'(1);
                    end
                end
                default: begin
                    state_d  = StOff;
                    dt_cnt_d = '0;
                end
            endcase
        end
        // Gates follow the next state so they switch on the same edge as the state.
        gate_hi_d = (state_d == StHi);
        gate_lo_d = (state_d == StLo);
    end

    // State register and registered gate outputs; reset drops gates asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StOff;
            tgt_hi_q  <= 1'b0;
            dt_cnt_q  <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_hi_q  <= tgt_hi_d;
            dt_cnt_q  <= dt_cnt_d;
            gate_hi_q <= gate_hi_d;
            gate_lo_q <= gate_lo_d;
        end
    end

    assign gate_hi     = gate_hi_q;
    assign gate_lo     = gate_lo_q;
    assign duty_active = duty_active_q;
    assign update_tick = update_tick_q;

endmodule
